// File: rtl/clock24_pkg.sv
// Shared definitions for the 24-hour BCD time keeper.
// Contents: the set-mode state enum, the BCD constants and default field
// limits, and the bit positions of the per-field blink mask.
package clock24_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] HMAX_DEF = 8'h23;
  localparam logic [7:0] MMAX_DEF = 8'h59;

  localparam int BLK_H = 2;
  localparam int BLK_M = 1;
  localparam int BLK_S = 0;

endpackage

// File: rtl/bcd_field_cnt.sv
// Two-digit BCD field counter (one hour, minute or second field).
// Ports:
//   CLK, RST  : clock, asynchronous active-low reset
//   inc       : advance the field by one, wrapping at max
//   clr       : force the field to 00 (has priority over inc)
//   max       : last legal value before wrap (BCD)
//   value     : registered BCD field value
//   wrap      : combinational, high when an inc is turning max into 00
module bcd_field_cnt
  import clock24_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  input  logic       clr,
  input  logic [7:0] max,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q, value_d;
  logic       bad;

  // A field that somehow holds an invalid digit or a value beyond max is
  // recovered to 00 on its next increment rather than counting onward.
  assign bad   = (value_q[7:4] > 4'd9) || (value_q[3:0] > 4'd9) || (value_q > max);
  assign wrap  = inc && (value_q == max);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = BCD_ZERO;
    end else if (inc) begin
      if (wrap || bad)
        value_d = BCD_ZERO;
      else if (value_q[3:0] == 4'd9)
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      else
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) value_q <= BCD_ZERO;
    else      value_q <= value_d;
  end

endmodule

// File: rtl/time_keeper_24h.sv
// 24-hour BCD time-of-day counter with button-driven set mode.
// Ports:
//   CLK, RST  : clock, asynchronous active-low reset
//   EN1HZ     : one-cycle tick per second from the prescaler
//   SIG2HZ    : 2 Hz square wave for blinking the field being set
//   MODE, UP  : debounced one-cycle button pulses
//   HOUR/MIN/SEC : registered BCD time fields
//   BLANK     : {hour,min,sec} blank mask, follows SIG2HZ one cycle late
//   DAYCARRY  : one-cycle pulse on the midnight rollover
//   SETTING   : high while in any set state
//
// state | meaning
// RUN   | time advances on EN1HZ, UP ignored
// SET_H | time frozen, UP increments hours (no carry)
// SET_M | time frozen, UP increments minutes (no carry)
// SET_S | time frozen, UP clears seconds
module time_keeper_24h #(
  parameter logic [7:0] HMAX = clock24_pkg::HMAX_DEF,
  parameter logic [7:0] MMAX = clock24_pkg::MMAX_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SIG2HZ,
  input  logic       MODE,
  input  logic       UP,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic [2:0] BLANK,
  output logic       DAYCARRY,
  output logic       SETTING
);
  import clock24_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] blank_q, blank_d;
  logic       daycarry_q, daycarry_d;
  logic       setting_q, setting_d;

  logic run, up_ok;
  logic sec_inc, sec_clr, min_inc, hour_inc;
  logic sec_wrap, min_wrap, hour_wrap;

  // MODE wins over UP in every set state; the carry chain exists only in RUN
  // so set-mode wraps never ripple into a neighbouring field.
  assign run      = (state_q == RUN);
  assign up_ok    = UP && !MODE;
  assign sec_inc  = run && EN1HZ;
  assign sec_clr  = (state_q == SET_S) && up_ok;
  assign min_inc  = run ? sec_wrap : ((state_q == SET_M) && up_ok);
  assign hour_inc = run ? min_wrap : ((state_q == SET_H) && up_ok);

  bcd_field_cnt u_sec (
    .CLK(CLK), .RST(RST), .inc(sec_inc), .clr(sec_clr), .max(MMAX),
    .value(SEC), .wrap(sec_wrap)
  );

  bcd_field_cnt u_min (
    .CLK(CLK), .RST(RST), .inc(min_inc), .clr(1'b0), .max(MMAX),
    .value(MIN), .wrap(min_wrap)
  );

  bcd_field_cnt u_hour (
    .CLK(CLK), .RST(RST), .inc(hour_inc), .clr(1'b0), .max(HMAX),
    .value(HOUR), .wrap(hour_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (MODE) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end

    // Blank mask and SETTING are decoded from the next state so they line up
    // with the registered state they describe.
    blank_d = 3'b000;
    case (state_d)
      SET_H:   blank_d[BLK_H] = SIG2HZ;
      SET_M:   blank_d[BLK_M] = SIG2HZ;
      SET_S:   blank_d[BLK_S] = SIG2HZ;
      default: blank_d = 3'b000;
    endcase

    setting_d  = (state_d != RUN);
    daycarry_d = run && hour_wrap;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= RUN;
      blank_q    <= 3'b000;
      daycarry_q <= 1'b0;
      setting_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      blank_q    <= blank_d;
      daycarry_q <= daycarry_d;
      setting_q  <= setting_d;
    end
  end

  assign BLANK    = blank_q;
  assign DAYCARRY = daycarry_q;
  assign SETTING  = setting_q;

endmodule

// File: tb/tb_time_keeper_24h.sv
module tb_time_keeper_24h;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN1HZ = 1'b0, SIG2HZ = 1'b0, MODE = 1'b0, UP = 1'b0;
  logic [7:0] HOUR, MIN, SEC, HOUR11, MIN11, SEC11;
  logic [2:0] BLANK, BLANK11;
  logic       DAYCARRY, SETTING, DAYCARRY11, SETTING11;

  int n_total = 0;
  int n_pass  = 0;
  logic dc_seen;

  always #5 CLK = ~CLK;

  time_keeper_24h dut (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ), .MODE(MODE), .UP(UP),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .BLANK(BLANK),
    .DAYCARRY(DAYCARRY), .SETTING(SETTING)
  );

  time_keeper_24h #(.HMAX(8'h11)) dut11 (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ), .MODE(MODE), .UP(UP),
    .HOUR(HOUR11), .MIN(MIN11), .SEC(SEC11), .BLANK(BLANK11),
    .DAYCARRY(DAYCARRY11), .SETTING(SETTING11)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle with the given pulses; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic e, input logic m, input logic u);
    @(negedge CLK);
    EN1HZ = e; MODE = m; UP = u;
    @(posedge CLK);
    #1;
    EN1HZ = 1'b0; MODE = 1'b0; UP = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_hour", HOUR, 8'h00);
    chk("rst_min", MIN, 8'h00);
    chk("rst_sec", SEC, 8'h00);
    chk("rst_blank", BLANK, 3'b000);
    chk("rst_daycarry", DAYCARRY, 1'b0);
    chk("rst_setting", SETTING, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    // Carry chain: 60 ticks, then on to 00:59:59 and 01:00:00
    for (int i = 1; i <= 60; i++) begin
      cyc(1, 0, 0);
      chk("chain_sec", SEC, to_bcd(i % 60));
    end
    chk("chain_min01", MIN, 8'h01);
    chk("chain_hour00", HOUR, 8'h00);
    dc_seen = 1'b0;
    for (int i = 0; i < 3539; i++) begin
      cyc(1, 0, 0);
      dc_seen = dc_seen | DAYCARRY;
    end
    chk("chain_005959", {HOUR, MIN, SEC}, 24'h005959);
    cyc(1, 0, 0);
    chk("chain_010000", {HOUR, MIN, SEC}, 24'h010000);
    chk("chain_010000_h11", {HOUR11, MIN11, SEC11}, 24'h010000);
    chk("chain_no_daycarry", dc_seen | DAYCARRY, 1'b0);

    // Simultaneous MODE+EN1HZ in RUN, MODE+UP in SET_H
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 0, 0);
    chk("sim_sec09", SEC, 8'h09);
    cyc(1, 1, 0);
    chk("sim_tick_applied", SEC, 8'h10);
    chk("sim_setting", SETTING, 1'b1);
    cyc(0, 1, 1);
    chk("sim_up_dropped", HOUR, 8'h00);
    cyc(0, 0, 1);
    chk("sim_in_set_m_min", MIN, 8'h01);
    chk("sim_in_set_m_hour", HOUR, 8'h00);

    // Blink in SET_M
    @(negedge CLK);
    SIG2HZ = 1'b1;
    @(posedge CLK);
    #1;
    chk("blink_m_hi", BLANK, 3'b010);
    @(negedge CLK);
    SIG2HZ = 1'b0;
    #1;
    chk("blink_m_late", BLANK, 3'b010);
    @(posedge CLK);
    #1;
    chk("blink_m_lo", BLANK, 3'b000);
    SIG2HZ = 1'b1;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("set_m_min03", MIN, 8'h03);
    chk("blink_m_hi2", BLANK, 3'b010);

    // Asynchronous reset between edges
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_time", {HOUR, MIN, SEC}, 24'h000000);
    chk("arst_blank", BLANK, 3'b000);
    chk("arst_setting", SETTING, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    SIG2HZ = 1'b0;
    cyc(1, 0, 0);
    chk("arst_run_tick", {HOUR, MIN, SEC}, 24'h000001);
    chk("arst_run_setting", SETTING, 1'b0);
    cyc(0, 0, 1);
    chk("run_up_ignored", {HOUR, MIN, SEC}, 24'h000001);

    // Set flow
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("set_h_entered", SETTING, 1'b1);
    chk("set_h_sec07", SEC, 8'h07);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    chk("set_h_hour05", HOUR, 8'h05);
    chk("set_h_hour05_h11", HOUR11, 8'h05);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("set_h_frozen", {HOUR, MIN, SEC}, 24'h050007);
    cyc(0, 1, 0);
    for (int i = 0; i < 61; i++) cyc(0, 0, 1);
    chk("set_m_min01", MIN, 8'h01);
    chk("set_m_no_hour_carry", HOUR, 8'h05);
    cyc(1, 0, 0);
    chk("set_m_frozen", SEC, 8'h07);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("set_s_frozen", SEC, 8'h07);
    cyc(0, 0, 1);
    chk("set_s_clear", SEC, 8'h00);
    cyc(0, 0, 1);
    chk("set_s_clear_again", SEC, 8'h00);
    cyc(1, 1, 0);
    chk("set_s_tick_dropped", {HOUR, MIN, SEC}, 24'h050100);
    chk("set_s_to_run", SETTING, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      SIG2HZ = ~SIG2HZ;
      @(posedge CLK);
      #1;
      chk("run_blank", BLANK, 3'b000);
    end
    SIG2HZ = 1'b0;
    cyc(1, 0, 0);
    chk("run_resumes", SEC, 8'h01);

    // Day rollover, HMAX=23 and HMAX=11
    do_reset();
    cyc(0, 1, 0);
    for (int i = 0; i < 23; i++) cyc(0, 0, 1);
    chk("roll_hour23", HOUR, 8'h23);
    chk("roll_hour11_h11", HOUR11, 8'h11);
    cyc(0, 1, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("roll_run", SETTING, 1'b0);
    dc_seen = 1'b0;
    for (int i = 0; i < 59; i++) begin
      cyc(1, 0, 0);
      dc_seen = dc_seen | DAYCARRY | DAYCARRY11;
    end
    chk("roll_235959", {HOUR, MIN, SEC}, 24'h235959);
    chk("roll_115959_h11", {HOUR11, MIN11, SEC11}, 24'h115959);
    chk("roll_no_early_carry", dc_seen, 1'b0);
    cyc(1, 0, 0);
    chk("roll_000000", {HOUR, MIN, SEC}, 24'h000000);
    chk("roll_daycarry", DAYCARRY, 1'b1);
    chk("roll_000000_h11", {HOUR11, MIN11, SEC11}, 24'h000000);
    chk("roll_daycarry_h11", DAYCARRY11, 1'b1);
    cyc(0, 0, 0);
    chk("roll_daycarry_1cyc", DAYCARRY, 1'b0);
    chk("roll_daycarry_1cyc_h11", DAYCARRY11, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
